// File: rtl/accumulator_ctrl.sv
// Sequencer for accumulator_bank: writes/accumulates K-tile psums, then drains rows under valid/ready.
// Optional DRAIN back-pressure counter enabled by defining ACC_CTRL_PERF_CNT_EN.
module accumulator_ctrl #(
  parameter int unsigned ROWS_MAX = 16,
  parameter int unsigned KT_W     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      cfg_rows,
  input  logic [KT_W-1:0] cfg_k_tiles,
  input  logic            psum_valid,
  input  logic            out_ready,
  output logic [3:0]      acc_addr,
  output logic            acc_wr_en,
  output logic            acc_mode,
  output logic            out_valid,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [31:0]     perf_stall_cnt
);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

  state_e          state_q;
  logic [3:0]      row_cnt_q;
  logic [KT_W-1:0] k_cnt_q;
  logic [4:0]      rows_q;
  logic [KT_W-1:0] kt_q;
  logic            err_q;

  logic cfg_ok;
  logic start_ok;
  logic row_last;
  logic k_last;
  logic stray;

  assign cfg_ok   = (cfg_rows != 5'd0) && ({27'd0, cfg_rows} <= ROWS_MAX)
                    && (cfg_k_tiles != '0);
  assign start_ok = (state_q == StIdle) && start && cfg_ok;
  assign row_last = ({1'b0, row_cnt_q} == (rows_q - 5'd1));
  assign k_last   = (k_cnt_q == (kt_q - KT_W'(1)));
  // Rows only enter the bank while accumulating; anything else is a protocol error.
  assign stray    = psum_valid && (state_q != StAccum);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      k_cnt_q   <= '0;
      rows_q    <= '0;
      kt_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= stray;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_ok) begin
              rows_q    <= cfg_rows;
              kt_q      <= cfg_k_tiles;
              row_cnt_q <= '0;
              k_cnt_q   <= '0;
              state_q   <= StAccum;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (psum_valid) begin
            if (row_last) begin
              row_cnt_q <= '0;
              k_cnt_q   <= k_cnt_q + KT_W'(1);
              if (k_last) state_q <= StDrain;
            end else begin
              row_cnt_q <= row_cnt_q + 4'd1;
            end
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (row_last) begin
              row_cnt_q <= '0;
              state_q   <= StDone;
            end else begin
              row_cnt_q <= row_cnt_q + 4'd1;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    acc_addr  = 4'd0;
    acc_wr_en = 1'b0;
    acc_mode  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state_q)
      StAccum: begin
        acc_addr  = row_cnt_q;
        acc_wr_en = psum_valid;
        acc_mode  = (k_cnt_q != '0);
      end
      StDrain: begin
        acc_addr  = row_cnt_q;
        out_valid = 1'b1;
        out_last  = row_last;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign err  = err_q;

`ifdef ACC_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (start_ok) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StDrain) && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/accumulator_ctrl.md
# accumulator_ctrl

Sequencer for `accumulator_bank`. It drives the bank's broadcast `addr`, `wr_en` and `acc_mode` through a full output tile in two phases:

- **ACCUM:** K-tile partial sums streamed from the systolic array are written on the first K-tile and accumulated on every later one.
- **DRAIN:** each accumulated row is presented downstream under a valid/ready handshake.

It sits between the systolic-array output stage and the post-processing/writeback path, and is the only driver of the bank's control inputs.

## Interface
Parameters:
- `ROWS_MAX`, 16: bank depth; must equal the depth addressed by the 4-bit bank `addr`.
- `KT_W`, 8: width of the K-tile count.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request to begin a tile; sampled only in IDLE.
- `cfg_rows` in 5: rows per tile, legal 1..16; latched on accepted `start`.
- `cfg_k_tiles` in KT_W: K-tiles to accumulate, legal 1..255; latched on accepted `start`.
- `psum_valid` in 1: the systolic array presents one row psum vector this cycle.
- `out_ready` in 1: downstream accepts the drained row.
- `acc_addr` out 4: to bank `addr`.
- `acc_wr_en` out 1: to bank `wr_en`.
- `acc_mode` out 1: to bank `acc_mode`; 0 = overwrite, 1 = accumulate.
- `out_valid` out 1: bank `out_acc_vec` at `acc_addr` is a valid drained row.
- `out_last` out 1: the current drained row is the last row of the tile.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at tile completion.
- `err` out 1: one-cycle pulse on a rejected `start` or a stray `psum_valid`.
- `perf_stall_cnt` out 32: DRAIN back-pressure cycles (see Configuration).

## Operation
- **States:** IDLE, ACCUM, DRAIN, DONE.
- **Registers:**
  - `row_cnt`: 4 bits.
  - `k_cnt`: KT_W bits.
  - latched `rows_q` and `kt_q`.
- **IDLE:**
  - `start` with legal config: latch config, clear counters, go to ACCUM.
  - `start` with `cfg_rows`=0, `cfg_rows`>16 or `cfg_k_tiles`=0: pulse `err`, stay in IDLE.
- **ACCUM:**
  - `acc_addr` = `row_cnt`.
  - `acc_wr_en` = `psum_valid`, combinational.
  - `acc_mode` = (`k_cnt` != 0).
  - Each `psum_valid` increments `row_cnt`.
  - When `row_cnt` = `rows_q`-1: `row_cnt` wraps to 0 and `k_cnt` increments.
  - On the `psum_valid` for row `rows_q`-1 of K-tile `kt_q`-1: go to DRAIN with `row_cnt`=0.
- **DRAIN:**
  - `acc_wr_en`=0, `acc_addr` = `row_cnt`, `out_valid`=1.
  - `out_last` = (`row_cnt` = `rows_q`-1).
  - `out_valid & out_ready` advances `row_cnt`.
  - Handshake on the last row: go to DONE.
  - `psum_valid` in this state pulses `err` and is not written.
- **DONE:** `done`=1 for one cycle, then IDLE. `busy` stays high in DONE.
- `psum_valid` in IDLE or DONE pulses `err`; no write occurs.
- `start` outside IDLE is ignored (no `err`).
- Bank rows at or above `rows_q` are never addressed.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - State goes to IDLE, counters clear.
  - All outputs 0 the following cycle, including `perf_stall_cnt`.
  - Takes effect mid-ACCUM or mid-DRAIN with no completion `done`. Bank contents are undefined to the consumer afterwards.
- `start` accepted at edge N: `busy`=1 from cycle N+1, and the first write is possible in cycle N+1.
- Write latency is 0: the bank captures the row at the same edge `psum_valid` is high.
- `psum_valid` may be continuous (1 row/cycle) or gapped; gaps hold all counters.
- Minimum tile time is `rows_q`·`kt_q` + `rows_q` + 2 cycles from `start`:
  - one start cycle;
  - `rows_q`·`kt_q` writes;
  - `rows_q` drain handshakes with `out_ready`=1;
  - one DONE cycle.
- DRAIN: `out_valid` stays high and `acc_addr` stays stable until `out_ready`. The read data is combinational from the bank at the current `acc_addr`.
- The first drained row is valid in the cycle after the last write (write-to-read spacing ≥1 cycle).
- `done` asserts in the cycle after the last drain handshake; `busy` drops one cycle later.

## Configuration
- Macro: `ACC_CTRL_PERF_CNT_EN`.
- **Defined:** `perf_stall_cnt`
  - increments by 1 each cycle in DRAIN with `out_valid` & !`out_ready`;
  - saturates at 2^32-1;
  - clears on an accepted `start`;
  - holds its value in IDLE.
- **Undefined:** `perf_stall_cnt` is tied to 0 and no counter logic is synthesized. The port is always present.

## Test plan
- **Basic tile:** `cfg_rows`=4, `cfg_k_tiles`=3, continuous `psum_valid`, `out_ready`=1.
  - Writes at addr 0,1,2,3 ×3, with `acc_mode` 0,0,0,0 then 1s.
  - Drain addr 0..3 with `out_last` on addr 3.
  - `done` at cycle 18 after `start`.
- **Back-pressure:** same config, `out_ready` low for 5 cycles at drain row 2 → `acc_addr` held at 2 with `out_valid`=1 throughout; `perf_stall_cnt`=5 with the macro defined, 0 without.
- **Illegal config:** `cfg_rows`=0, `cfg_rows`=17 and `cfg_k_tiles`=0 → `err` pulses each time, `busy` stays 0, no `acc_wr_en`.
- **Gapped input:** `cfg_rows`=16, `cfg_k_tiles`=1, `psum_valid` alternating 1/0 → 16 writes at addr 0..15, all with `acc_mode`=0; counters hold in the gap cycles.
- **Stray input:** `psum_valid` in IDLE and during DRAIN → `err` pulses and `acc_wr_en` stays 0.
- **Reset mid-ACCUM:** `rst_n`=0 for 1 cycle after 5 writes → all outputs 0 and no `done`; a new `start` with `cfg_rows`=2, `cfg_k_tiles`=1 completes normally with first write `acc_mode`=0.
